pos_cell_reader: RTL

// - Streaming read engine in front of one position cell memory (cell_x_y_z, 2-cycle read latency).
// - On start, reads the particle count at address 0, then reads particles 1..N in order.
// - Emits {posz,posy,posx} plus particle index on a valid/ready stream to the force-evaluation

---
 rtl/pos_cell_reader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pos_cell_reader.sv
`default_nettype none
// ============================================================================
// Module   : pos_cell_reader
// Brief    : Reads a particle count and then particles 1..N from a cell memory,
//            streaming them through a credit-limited first-word-fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module pos_cell_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pid
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [CNT_W:0]        CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]      LAST_SLOT = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_CNT   = 3'd1,
        S_WAIT_CNT = 3'd2,
        S_STREAM   = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  wait_phase;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] raw_count;
    logic [ADDR_WIDTH-1:0] count_clamped;
    logic                  count_over;
    logic                  count_load;
    logic                  issue;

    logic                  tag_v1;
    logic                  tag_v2;
    logic [ADDR_WIDTH-1:0] tag_pid1;
    logic [ADDR_WIDTH-1:0] tag_pid2;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pid  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      fifo_count_nxt;
    logic [CNT_W:0]        credit_sum;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;

    // Count word arrives on the second WAIT_CNT cycle (2-cycle RAM latency).
    assign raw_count     = rd_data[ADDR_WIDTH-1:0];
    assign count_over    = (raw_count > MAX_COUNT);
    assign count_clamped = count_over ? MAX_COUNT : raw_count;
    assign count_load    = (state == S_WAIT_CNT) && wait_phase;

    assign push           = tag_v2;
    assign pop            = out_valid && out_ready;
    assign fifo_full      = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

    // Every issued read either sits in the tag pipe or in the FIFO until popped.
    assign credit_sum = {1'b0, fifo_count} + (CNT_W + 1)'(tag_v1) + (CNT_W + 1)'(tag_v2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_phase <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_phase <= (state == S_WAIT_CNT) && !wait_phase;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RD_CNT;
                end
            end
            S_RD_CNT: begin
                state_nxt = S_WAIT_CNT;
            end
            S_WAIT_CNT: begin
                if (wait_phase) begin
                    state_nxt = (count_clamped == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                issue = (credit_sum < CREDITS);
                if (issue && (next_addr == particle_count)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!tag_v1 && !tag_v2 && (fifo_count_nxt == '0)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign rd_en   = (state == S_RD_CNT) || issue;
    assign rd_addr = (state == S_STREAM) ? next_addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            particle_count <= '0;
            count_err      <= 1'b0;
            next_addr      <= '0;
        end else if (count_load) begin
            particle_count <= count_clamped;
            next_addr      <= ADDR_WIDTH'(1);
            if (count_over) begin
                count_err <= 1'b1;
            end
        end else if (issue) begin
            next_addr <= next_addr + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v1   <= 1'b0;
            tag_v2   <= 1'b0;
            tag_pid1 <= '0;
            tag_pid2 <= '0;
        end else begin
            tag_v1   <= issue;
            tag_pid1 <= next_addr;
            tag_v2   <= tag_v1;
            tag_pid2 <= tag_pid1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= rd_data;
            fifo_pid[wr_ptr]  <= tag_pid2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count_nxt;
        end
    end

    // Outputs are forced to zero while empty so nothing stale is visible.
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_pid   = out_valid ? fifo_pid[rd_ptr]  : '0;

    a_no_push_on_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule
`default_nettype wire
